contador_param: RTL and testbench

//  Parametrised synchronous up/down/load counter built from NSEG segments of SEG_W bits.

---
 rtl/contador_param.sv | 111 +++++++++++
 tb/tb_contador_param.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/contador_param.sv
// Segmented up/down/load counter: NSEG slices of SEG_W bits chained by a ripple carry,
// with registered per-segment carry/borrow flags and optional clamping at the full-width limit.

module contador_seg #(
  parameter int SEG_W = 4
) (
  input  logic [SEG_W-1:0] a_i,
  input  logic [SEG_W-1:0] b_i,
  input  logic             c_i,
  output logic [SEG_W-1:0] s_o,
  output logic             c_o
);
  assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{SEG_W{1'b0}}, c_i};
endmodule

module contador_param #(
  parameter int SEG_W = 4,
  parameter int NSEG  = 4,
  parameter int SAT   = 0
) (
  input  logic                    CLK,
  input  logic                    RST_L,
  input  logic                    ENB,
  input  logic [1:0]              MODO,
  input  logic [SEG_W*NSEG-1:0]   D,
  output logic [SEG_W*NSEG-1:0]   Q,
  output logic [NSEG-1:0]         RCO,
  output logic                    SATF
);
  localparam int W = SEG_W * NSEG;

  typedef enum logic [1:0] {
    M_UP  = 2'b00,
    M_DN1 = 2'b01,
    M_DN3 = 2'b10,
    M_LD  = 2'b11
  } modo_e;

  logic [W-1:0]    q_q, q_d;
  logic [NSEG-1:0] rco_q, rco_d;
  logic            satf_q, satf_d;

  logic [W-1:0]    addend;
  logic [W-1:0]    sum;
  logic [NSEG:0]   cy;
  logic [NSEG-1:0] rco_raw;
  logic            up;
  logic            wrap;

  assign up = (MODO == M_UP);

  // Down steps are added as two's complement; assumes W >= 2 so -3 fits.
  always_comb begin
    addend = '0;
    case (MODO)
      M_UP:    addend = W'(1);
      M_DN1:   addend = '1;
      M_DN3:   addend = ~W'(2);
      default: addend = '0;
    endcase
  end

  assign cy[0] = 1'b0;

  // Carry out of slice k means the lower field L_k rolled over (up) or did not borrow (down).
  for (genvar g = 0; g < NSEG; g++) begin : g_seg
    contador_seg #(.SEG_W(SEG_W)) u_seg (
      .a_i (q_q[g*SEG_W +: SEG_W]),
      .b_i (addend[g*SEG_W +: SEG_W]),
      .c_i (cy[g]),
      .s_o (sum[g*SEG_W +: SEG_W]),
      .c_o (cy[g+1])
    );
    assign rco_raw[g] = up ? cy[g+1] : ~cy[g+1];
  end

  assign wrap = rco_raw[NSEG-1];

  always_comb begin
    q_d    = q_q;
    rco_d  = '0;
    satf_d = 1'b0;
    if (ENB) begin
      if (MODO == M_LD) begin
        q_d = D;
      end else if ((SAT != 0) && wrap) begin
        q_d    = up ? '1 : '0;
        satf_d = 1'b1;
      end else begin
        q_d   = sum;
        rco_d = rco_raw;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_L) begin
      q_q    <= '0;
      rco_q  <= '0;
      satf_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      rco_q  <= rco_d;
      satf_q <= satf_d;
    end
  end

  assign Q    = q_q;
  assign RCO  = rco_q;
  assign SATF = satf_q;
endmodule

// File: tb/tb_contador_param.sv
// Scoreboard bench: three counters (16b wrap, 16b saturating, 6b wrap) checked against a field model.

module tb_contador_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, enb0, satf0;
  logic [1:0]  modo0;
  logic [15:0] d0, q0;
  logic [3:0]  rco0;
  logic        rst1, enb1, satf1;
  logic [1:0]  modo1;
  logic [15:0] d1, q1;
  logic [3:0]  rco1;
  logic        rst2, enb2, satf2;
  logic [1:0]  modo2;
  logic [5:0]  d2, q2;
  logic [1:0]  rco2;

  contador_param #(.SEG_W(4), .NSEG(4), .SAT(0)) u0 (
    .CLK(clk), .RST_L(rst0), .ENB(enb0), .MODO(modo0), .D(d0), .Q(q0), .RCO(rco0), .SATF(satf0));
  contador_param #(.SEG_W(4), .NSEG(4), .SAT(1)) u1 (
    .CLK(clk), .RST_L(rst1), .ENB(enb1), .MODO(modo1), .D(d1), .Q(q1), .RCO(rco1), .SATF(satf1));
  contador_param #(.SEG_W(3), .NSEG(2), .SAT(0)) u2 (
    .CLK(clk), .RST_L(rst2), .ENB(enb2), .MODO(modo2), .D(d2), .Q(q2), .RCO(rco2), .SATF(satf2));

  typedef struct {
    int          u;
    logic [31:0] q;
    logic [31:0] rco;
    logic        satf;
  } exp_t;

  exp_t        sb[$];
  int          nchk = 0;
  int          nerr = 0;
  int          SW[3] = '{4, 4, 3};
  int          NS[3] = '{4, 4, 2};
  int          SA[3] = '{0, 1, 0};
  logic        rst_v[3];
  logic        enb_v[3];
  logic [1:0]  modo_v[3];
  logic [31:0] d_v[3];
  logic [31:0] mq[3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void mdl(input int segw, input int nseg, input int sat,
                              input logic [31:0] q, input logic rst, input logic enb,
                              input logic [1:0] m, input logic [31:0] d,
                              output logic [31:0] nq, output logic [31:0] nr, output logic ns);
    logic [63:0] mask, lq, lk, lim, s;
    logic        upd, wr;
    int          w;
    w    = segw * nseg;
    mask = (64'd1 << w) - 64'd1;
    lq   = {32'd0, q};
    nq = 32'd0; nr = 32'd0; ns = 1'b0;
    if (!rst) return;
    if (!enb) begin nq = q; return; end
    if (m == 2'b11) begin nq = 32'(d & mask); return; end
    upd = (m == 2'b00);
    s   = (m == 2'b10) ? 64'd3 : 64'd1;
    for (int k = 0; k < nseg; k++) begin
      lim = (64'd1 << ((k + 1) * segw)) - 64'd1;
      lk  = lq & lim;
      nr[k] = upd ? (lk == lim) : (lk < s);
    end
    wr = upd ? (lq == mask) : (lq < s);
    if (sat != 0 && wr) begin
      nq = upd ? 32'(mask) : 32'd0;
      nr = 32'd0;
      ns = 1'b1;
    end else begin
      nq = upd ? 32'((lq + 64'd1) & mask) : 32'((lq - s) & mask);
    end
  endfunction

  task automatic idle();
    for (int u = 0; u < 3; u++) begin
      rst_v[u] = 1'b1; enb_v[u] = 1'b0; modo_v[u] = 2'b00; d_v[u] = 32'd0;
    end
  endtask

  task automatic set(input int u, input logic r, input logic e, input logic [1:0] m,
                     input logic [31:0] d);
    idle();
    rst_v[u] = r; enb_v[u] = e; modo_v[u] = m; d_v[u] = d;
  endtask

  task automatic tick();
    exp_t        e;
    logic [31:0] nq, nr, aq, ar;
    logic        ns, as;
    for (int u = 0; u < 3; u++) begin
      mdl(SW[u], NS[u], SA[u], mq[u], rst_v[u], enb_v[u], modo_v[u], d_v[u], nq, nr, ns);
      mq[u] = nq;
      e.u = u; e.q = nq; e.rco = nr; e.satf = ns;
      sb.push_back(e);
    end
    rst0 = rst_v[0]; enb0 = enb_v[0]; modo0 = modo_v[0]; d0 = d_v[0][15:0];
    rst1 = rst_v[1]; enb1 = enb_v[1]; modo1 = modo_v[1]; d1 = d_v[1][15:0];
    rst2 = rst_v[2]; enb2 = enb_v[2]; modo2 = modo_v[2]; d2 = d_v[2][5:0];
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.u)
        0:       begin aq = {16'd0, q0}; ar = {28'd0, rco0}; as = satf0; end
        1:       begin aq = {16'd0, q1}; ar = {28'd0, rco1}; as = satf1; end
        default: begin aq = {26'd0, q2}; ar = {30'd0, rco2}; as = satf2; end
      endcase
      chk($sformatf("u%0d_q", e.u), aq, e.q);
      chk($sformatf("u%0d_rco", e.u), ar, e.rco);
      chk($sformatf("u%0d_satf", e.u), {31'd0, as}, {31'd0, e.satf});
    end
  endtask

  initial begin
    for (int u = 0; u < 3; u++) mq[u] = 32'd0;
    // reset with count requested, then held low
    for (int u = 0; u < 3; u++) begin
      rst_v[u] = 1'b0; enb_v[u] = 1'b1; modo_v[u] = 2'b00; d_v[u] = 32'd0;
    end
    repeat (4) tick();
    chk("rst_q_direct", {16'd0, q0}, 32'h0000);

    // load 0x00FF then count up across two segment boundaries
    set(0, 1, 1, 2'b11, 32'h00FF); tick();
    set(0, 1, 1, 2'b00, 32'h0);    tick();
    chk("t2_q_direct", {16'd0, q0}, 32'h0100);
    chk("t2_rco_direct", {28'd0, rco0}, 32'h3);
    tick();

    // full-width borrow by 3
    set(0, 1, 1, 2'b11, 32'h0001); tick();
    set(0, 1, 1, 2'b10, 32'h0);    tick();
    chk("t3_q_direct", {16'd0, q0}, 32'hFFFE);
    tick();
    chk("t3_q2_direct", {16'd0, q0}, 32'hFFFB);

    // full-width carry with an enable gap
    set(0, 1, 1, 2'b11, 32'hFFFF); tick();
    set(0, 1, 1, 2'b00, 32'h0);    tick();
    set(0, 1, 0, 2'b00, 32'h0);    tick();
    set(0, 1, 1, 2'b00, 32'h0);    tick();
    chk("t4_q_direct", {16'd0, q0}, 32'h0001);

    // saturation clamps at zero and reasserts, clears on a normal step
    set(1, 1, 1, 2'b11, 32'h0002); tick();
    set(1, 1, 1, 2'b10, 32'h0);    tick(); tick();
    chk("t5_satf_direct", {31'd0, satf1}, 32'h1);
    set(1, 1, 1, 2'b00, 32'h0);    tick();
    chk("t5_q_direct", {16'd0, q1}, 32'h0001);
    set(1, 1, 1, 2'b11, 32'hFFFE); tick();
    set(1, 1, 1, 2'b00, 32'h0);    tick(); tick(); tick();

    // reset mid-count, then release counting down
    set(0, 1, 1, 2'b11, 32'h1234); tick();
    set(0, 1, 1, 2'b01, 32'h0);    tick(); tick();
    set(0, 0, 1, 2'b01, 32'h0);    tick();
    set(0, 1, 1, 2'b01, 32'h0);    tick();
    chk("t6_q_direct", {16'd0, q0}, 32'hFFFF);
    chk("t6_rco_direct", {28'd0, rco0}, 32'hF);

    // narrow configuration: segment carry and full-width borrow
    set(2, 1, 1, 2'b11, 32'h07); tick();
    set(2, 1, 1, 2'b00, 32'h0);  tick(); tick();
    set(2, 1, 1, 2'b11, 32'h01); tick();
    set(2, 1, 1, 2'b10, 32'h0);  tick();
    chk("t7_q_direct", {26'd0, q2}, 32'h3E);
    tick();

    // random traffic biased toward the wrap limits
    repeat (400) begin
      for (int u = 0; u < 3; u++) begin
        rst_v[u]  = ($urandom_range(0, 19) != 0);
        enb_v[u]  = ($urandom_range(0, 3) != 0);
        modo_v[u] = 2'($urandom_range(0, 3));
        d_v[u]    = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3))
                                                 : 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
